// File: rtl/rvvi_depacketizer.sv
// rvvi_depacketizer: receive side of the RVVI-over-Ethernet trace link.
// Collects a word-burst frame into a buffer, checks DstMac/EthType, and
// hands one reassembled RVVI record per good frame to the consumer.
// Optional macro RVVI_DEPKT_ERR_CNT_EN adds saturating drop counters
// (ErrHdrCount, ErrShortCount, ErrLongCount).
module rvvi_depacketizer #(
    parameter int          PAYLOAD_BITS = 632,
    parameter logic [47:0] LOCAL_MAC    = 48'h8F54_0000_1654,
    parameter logic [15:0] ETH_TYPE     = 16'h005C
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_aresetn,
    input  logic [31:0]             RvviAxiRdata,
    input  logic                    RvviAxiRvalid,
    input  logic                    RvviAxiRlast,
    output logic                    RvviAxiRready,
    output logic [PAYLOAD_BITS-1:0] Rvvi,
    output logic                    RvviValid,
    input  logic                    RvviReady,
    output logic [31:0]             FrameCount,
`ifdef RVVI_DEPKT_ERR_CNT_EN
    output logic [15:0]             ErrHdrCount,
    output logic [15:0]             ErrShortCount,
    output logic [15:0]             ErrLongCount,
`endif
    output logic [47:0]             SrcMacLast
);

    localparam int FRAME_WORDS = (112 + PAYLOAD_BITS + 31) / 32;
    localparam int BUF_BITS    = FRAME_WORDS * 32;
    localparam logic [9:0] LAST_IDX = 10'(FRAME_WORDS - 1);

    localparam logic [1:0] S_RECV = 2'd0;
    localparam logic [1:0] S_DROP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    if (FRAME_WORDS > 1023) begin : g_bad_cfg
        $error("FRAME_WORDS exceeds 10-bit word counter");
    end

    logic [1:0]              state_q, state_d;
    logic [9:0]              wcnt_q, wcnt_d;
    logic                    bad_q, bad_d;
    logic [BUF_BITS-1:0]     buf_q, buf_d;
    logic [PAYLOAD_BITS-1:0] rvvi_q, rvvi_d;
    logic [31:0]             fcnt_q, fcnt_d;
    logic [47:0]             smac_q, smac_d;
    logic                    beat, at_end, hdr_err;
    logic                    ev_hdr, ev_short, ev_long;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign RvviAxiRready = m_axi_aresetn & ((state_q == S_RECV) | (state_q == S_DROP));
    assign beat          = RvviAxiRvalid & RvviAxiRready;
    assign at_end        = (wcnt_q == LAST_IDX);
    assign RvviValid     = (state_q == S_HOLD);
    assign Rvvi          = rvvi_q;
    assign FrameCount    = fcnt_q;
    assign SrcMacLast    = smac_q;

    // Header word check for the word currently on the bus.
    always_comb begin
        hdr_err = 1'b0;
        case (wcnt_q)
            10'd1:   hdr_err = (RvviAxiRdata[31:16] != LOCAL_MAC[15:0]);
            10'd2:   hdr_err = (RvviAxiRdata != LOCAL_MAC[47:16]);
            10'd3:   hdr_err = (RvviAxiRdata[15:0] != ETH_TYPE);
            default: hdr_err = 1'b0;
        endcase
    end

    // Frame FSM; buf_d includes the word of this beat so the last word is
    // visible when the record is latched on the final beat.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        bad_d    = bad_q;
        buf_d    = buf_q;
        rvvi_d   = rvvi_q;
        fcnt_d   = fcnt_q;
        smac_d   = smac_q;
        ev_hdr   = 1'b0;
        ev_short = 1'b0;
        ev_long  = 1'b0;
        case (state_q)
            S_RECV: begin
                if (beat) begin
                    buf_d[{wcnt_q, 5'd0} +: 32] = RvviAxiRdata;
                    wcnt_d = wcnt_q + 10'd1;
                    bad_d  = bad_q | hdr_err;
                    if (at_end) begin
                        wcnt_d = '0;
                        bad_d  = 1'b0;
                        if (!RvviAxiRlast) begin
                            // Long frame: bad header is not counted separately.
                            state_d = S_DROP;
                            ev_long = 1'b1;
                        end else if (bad_q | hdr_err) begin
                            ev_hdr = 1'b1;
                        end else begin
                            state_d = S_HOLD;
                            rvvi_d  = buf_d[112 +: PAYLOAD_BITS];
                            smac_d  = buf_d[47:0];
                            fcnt_d  = fcnt_q + 32'd1;
                        end
                    end else if (RvviAxiRlast) begin
                        wcnt_d   = '0;
                        bad_d    = 1'b0;
                        ev_short = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (beat && RvviAxiRlast) begin
                    state_d = S_RECV;
                    wcnt_d  = '0;
                    bad_d   = 1'b0;
                end
            end
            S_HOLD: begin
                if (RvviReady) begin
                    state_d = S_RECV;
                    wcnt_d  = '0;
                end
            end
            default: state_d = S_RECV;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q <= S_RECV;
            wcnt_q  <= '0;
            bad_q   <= 1'b0;
            buf_q   <= '0;
            rvvi_q  <= '0;
            fcnt_q  <= '0;
            smac_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            bad_q   <= bad_d;
            buf_q   <= buf_d;
            rvvi_q  <= rvvi_d;
            fcnt_q  <= fcnt_d;
            smac_q  <= smac_d;
        end
    end

`ifdef RVVI_DEPKT_ERR_CNT_EN
    logic [15:0] err_hdr_q, err_short_q, err_long_q;

    assign ErrHdrCount   = err_hdr_q;
    assign ErrShortCount = err_short_q;
    assign ErrLongCount  = err_long_q;

    // Saturating drop counters.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            err_hdr_q   <= '0;
            err_short_q <= '0;
            err_long_q  <= '0;
        end else begin
            if (ev_hdr && err_hdr_q != 16'hFFFF)     err_hdr_q   <= err_hdr_q + 16'd1;
            if (ev_short && err_short_q != 16'hFFFF) err_short_q <= err_short_q + 16'd1;
            if (ev_long && err_long_q != 16'hFFFF)   err_long_q  <= err_long_q + 16'd1;
        end
    end
`else
    logic unused_ev;
    assign unused_ev = ev_hdr | ev_short | ev_long;
`endif

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer: table of frame vectors plus
// hand-written stall and mid-frame reset sequences.
module tb_rvvi_depacketizer;

    localparam int PB = 632;
    localparam int FW = 24;
    localparam logic [47:0] LMAC = 48'h8F54_0000_1654;
    localparam logic [15:0] ETH  = 16'h005C;
    localparam logic [15:0] BADETH = 16'h0800;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   rdata = '0;
    logic          rvalid = 1'b0;
    logic          rlast = 1'b0;
    logic          rready;
    logic [PB-1:0] rvvi;
    logic          rvvi_valid;
    logic          rvvi_ready = 1'b1;
    logic [31:0]   fcount;
    logic [47:0]   smac;
`ifdef RVVI_DEPKT_ERR_CNT_EN
    logic [15:0]   err_hdr, err_short, err_long;
`endif

    int tot_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    rvvi_depacketizer dut (
        .m_axi_aclk   (clk),
        .m_axi_aresetn(rst_n),
        .RvviAxiRdata (rdata),
        .RvviAxiRvalid(rvalid),
        .RvviAxiRlast (rlast),
        .RvviAxiRready(rready),
        .Rvvi         (rvvi),
        .RvviValid    (rvvi_valid),
        .RvviReady    (rvvi_ready),
        .FrameCount   (fcount),
`ifdef RVVI_DEPKT_ERR_CNT_EN
        .ErrHdrCount  (err_hdr),
        .ErrShortCount(err_short),
        .ErrLongCount (err_long),
`endif
        .SrcMacLast   (smac)
    );

    typedef struct {
        int          nwords;
        int          last_at;
        logic [15:0] eth;
        int          seed;
        logic        exp_valid;
        int          exp_fc;
        int          exp_hdr;
        int          exp_short;
        int          exp_long;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [PB-1:0] pay(input int seed);
        logic [PB-1:0] p;
        p = '0;
        for (int i = 0; i < PB / 8; i++) p[i*8 +: 8] = 8'(i + seed);
        return p;
    endfunction

    function automatic logic [47:0] src(input int seed);
        return 48'h4502_1111_6843 ^ 48'(seed);
    endfunction

    // Packs the frame LSB first with a nonzero pad, which must be ignored.
    function automatic logic [FW*32-1:0] mk_frame(input int seed, input logic [15:0] eth);
        return {24'hABCDEF, pay(seed), eth, LMAC, src(seed)};
    endfunction

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drives nwords beats starting at the next negedge; returns at the negedge
    // following the final accepted beat with rvalid dropped.
    task automatic send_frame(input int nwords, input int last_at, input logic [15:0] eth, input int seed);
        logic [FW*32-1:0] fr;
        int n;
        fr = mk_frame(seed, eth);
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            rvalid = 1'b1;
            rdata  = (i < FW) ? fr[i*32 +: 32] : (32'hDEAD0000 | 32'(i));
            rlast  = (i == last_at);
            n = 0;
            while (!rready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                tot_cnt++;
                $display("FAIL ready_timeout: word %0d never accepted", i);
                rvalid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    initial begin
        int bad;
        //         nw  last eth     seed valid fc hdr sh lg
        vecs[0]  = '{24, 23, ETH,    0,  1'b1, 1, 0, 0, 0};
        vecs[1]  = '{24, 23, BADETH, 1,  1'b0, 1, 1, 0, 0};
        vecs[2]  = '{24, 23, ETH,    5,  1'b1, 2, 1, 0, 0};
        vecs[3]  = '{11, 10, ETH,    6,  1'b0, 2, 1, 1, 0};
        vecs[4]  = '{24, 23, ETH,    9,  1'b1, 3, 1, 1, 0};
        vecs[5]  = '{30, 29, ETH,    10, 1'b0, 3, 1, 1, 1};
        vecs[6]  = '{24, 23, ETH,    13, 1'b1, 4, 1, 1, 1};
        vecs[7]  = '{30, 29, BADETH, 14, 1'b0, 4, 1, 1, 2};
        vecs[8]  = '{24, 23, ETH,    17, 1'b1, 5, 1, 1, 2};
        vecs[9]  = '{1,  0,  ETH,    18, 1'b0, 5, 1, 2, 2};
        vecs[10] = '{24, 23, ETH,    19, 1'b1, 6, 1, 2, 2};

        // Reset state
        #1;
        check("rst_valid", 640'(rvvi_valid), 640'(0));
        check("rst_rready", 640'(rready), 640'(0));
        check("rst_rvvi", 640'(rvvi), 640'(0));
        check("rst_fc", 640'(fcount), 640'(0));
        check("rst_smac", 640'(smac), 640'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            rvvi_ready = 1'b1;
            send_frame(vecs[k].nwords, vecs[k].last_at, vecs[k].eth, vecs[k].seed);
            check($sformatf("v%0d_valid", k), 640'(rvvi_valid), 640'(vecs[k].exp_valid));
            check($sformatf("v%0d_fc", k), 640'(fcount), 640'(vecs[k].exp_fc));
            if (vecs[k].exp_valid) begin
                check($sformatf("v%0d_rvvi", k), 640'(rvvi), 640'(pay(vecs[k].seed)));
                check($sformatf("v%0d_smac", k), 640'(smac), 640'(src(vecs[k].seed)));
            end
`ifdef RVVI_DEPKT_ERR_CNT_EN
            check($sformatf("v%0d_hdr", k), 640'(err_hdr), 640'(vecs[k].exp_hdr));
            check($sformatf("v%0d_short", k), 640'(err_short), 640'(vecs[k].exp_short));
            check($sformatf("v%0d_long", k), 640'(err_long), 640'(vecs[k].exp_long));
`endif
            @(negedge clk);
            check($sformatf("v%0d_valid_after", k), 640'(rvvi_valid), 640'(0));
        end

        // Consumer back-pressure: record held, next frame held off.
        rvvi_ready = 1'b0;
        send_frame(FW, FW - 1, ETH, 20);
        check("stall_valid", 640'(rvvi_valid), 640'(1));
        check("stall_fc", 640'(fcount), 640'(7));
        fork
            send_frame(FW, FW - 1, ETH, 21);
            begin
                bad = 0;
                repeat (10) begin
                    if (!rvvi_valid || rready || rvvi !== pay(20)) bad++;
                    @(negedge clk);
                end
                check("stall_stable_errs", 640'(bad), 640'(0));
                rvvi_ready = 1'b1;
            end
        join
        check("held_valid", 640'(rvvi_valid), 640'(1));
        check("held_rvvi", 640'(rvvi), 640'(pay(21)));
        check("held_fc", 640'(fcount), 640'(8));

        // Reset in the middle of a frame.
        send_frame(13, -1, ETH, 22);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 640'(rvvi_valid), 640'(0));
        check("mid_rst_rready", 640'(rready), 640'(0));
        check("mid_rst_rvvi", 640'(rvvi), 640'(0));
        check("mid_rst_fc", 640'(fcount), 640'(0));
        check("mid_rst_smac", 640'(smac), 640'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(FW, FW - 1, ETH, 23);
        check("post_rst_valid", 640'(rvvi_valid), 640'(1));
        check("post_rst_rvvi", 640'(rvvi), 640'(pay(23)));
        check("post_rst_smac", 640'(smac), 640'(src(23)));
        check("post_rst_fc", 640'(fcount), 640'(1));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/rvvi_depacketizer.md
Name: rvvi_depacketizer

Overview:
- Receive end of the RVVI-over-Ethernet trace link.
- Accepts the 32-bit word burst stream produced by the RVVI packetizer, or looped back from the Ethernet MAC RX path.
- Checks the frame header, reassembles the padded RVVI payload, and presents one RVVI record per good frame on a valid/ready interface to the host-side checker.
- Frame layout, LSB first: SrcMac[47:0], DstMac[47:0], EthType[15:0], payload[PAYLOAD_BITS-1:0], zero pad up to a 32-bit boundary. Word 0 carries frame bits [31:0].

Parameters:
- PAYLOAD_BITS, 632, RVVI record width (72 + 5*XLEN + MAX_CSRS*(XLEN+16) with XLEN=64, MAX_CSRS=3).
- FRAME_WORDS, derived = ceil((112+PAYLOAD_BITS)/32), 24 at default; localparam, not overridable.
- LOCAL_MAC, 48'h8F54_0000_1654, required DstMac.
- ETH_TYPE, 16'h005C, required EthType.

Ports:
- m_axi_aclk  in  1  sole clock.
- m_axi_aresetn  in  1  asynchronous, active-low reset.
- RvviAxiRdata  in  32  stream data word.
- RvviAxiRvalid  in  1  word valid.
- RvviAxiRlast  in  1  last word of frame.
- RvviAxiRready  out  1  block can accept a word.
- Rvvi  out  PAYLOAD_BITS  reassembled record.
- RvviValid  out  1  record valid.
- RvviReady  in  1  consumer accepts record.
- FrameCount  out  32  good frames delivered, wraps at 2^32.
- SrcMacLast  out  48  SrcMac of last good frame.

Behaviour:
- Reset is asynchronous and active-low on m_axi_aresetn. All registers clear; no synchronous reset.
- Reset values: RvviAxiRready=0, RvviValid=0, Rvvi=0, FrameCount=0, SrcMacLast=0, state=RECV, WordCount=0, Bad=0.
- A reset asserted mid-frame discards the partial frame. After release the block waits for a fresh frame starting at word 0.
- Beat = RvviAxiRvalid & RvviAxiRready. RvviAxiRready = (state==RECV | state==DROP) and is registered-free combinational from state.
- State RECV:
  - On each beat, store the word into frame buffer slot WordCount, then WordCount++.
  - Bad flag set on any of: word 1 [31:16] != LOCAL_MAC[15:0]; word 2 != LOCAL_MAC[47:16]; word 3 [15:0] != ETH_TYPE.
- Beat with RvviAxiRlast while WordCount < FRAME_WORDS-1 is a short frame: drop, clear WordCount/Bad, stay in RECV.
- Beat at WordCount == FRAME_WORDS-1:
  - Without last (long frame): go to DROP.
  - With last and Bad: drop, reset count, stay in RECV.
  - With last and !Bad: go to HOLD. Rvvi <= buffer payload bits, SrcMacLast <= header, FrameCount++.
- State DROP: absorb beats until a beat with last, then go to RECV with WordCount=0 and Bad=0.
- State HOLD:
  - RvviValid=1 and RvviAxiRready=0.
  - Rvvi is stable while RvviValid & !RvviReady.
  - When RvviReady=1: RvviValid goes 0 next cycle, state goes to RECV, WordCount=0.
- Latency: RvviValid rises on the cycle after the last beat is accepted.
- The pad bits are ignored; nonzero pad is not an error.
- Rvalid low mid-frame stalls indefinitely; no timeout.
- WordCount is 10 bits; FRAME_WORDS must be <= 1023 (elaboration assertion).
- Payload extraction uses constant bit offsets [112 +: PAYLOAD_BITS] into the FRAME_WORDS*32 buffer.

Optional Feature:
- Macro RVVI_DEPKT_ERR_CNT_EN.
- Defined: adds three 16-bit saturating output counters, each cleared at reset and saturating at 16'hFFFF:
  - ErrHdrCount: increments once per dropped Bad frame.
  - ErrShortCount: increments per short frame.
  - ErrLongCount: increments per long frame, counted on the transition into DROP.
  - A frame that is both Bad and long counts only as long.
- Undefined: counters and ports absent; drop behaviour is identical.

Test Plan:
- Reset then one good 24-word frame, payload = incrementing pattern, RvviReady=1 → RvviValid high one cycle after word 23, Rvvi matches pattern, FrameCount=1, SrcMacLast=48'h4502_1111_6843.
- Good frame with RvviReady held 0 for 10 cycles → RvviAxiRready=0 and Rvvi stable throughout. Next frame's words are held off and accepted intact once RvviReady=1; FrameCount=2.
- Frame with word 3 EthType=16'h0800 → no RvviValid, FrameCount unchanged, ErrHdrCount=1 (macro on). A following good frame is delivered.
- Rlast on word 10 (short) then a good frame → first dropped (ErrShortCount=1), second delivered correctly aligned.
- 30-word frame with last on word 29 → DROP from word 24, no output, ErrLongCount=1. Following good frame delivered.
- m_axi_aresetn pulsed low at word 12, then a full good frame → all outputs zero during reset; the subsequent frame is delivered and FrameCount=1.
